wb_trace_checker: RTL and testbench
===================================

Name: wb_trace_checker

Overview:
- Consumes the CPU core's writeback debug port (debug_wb_pc / debug_wb_rf_wen / debug_wb_rf_wnum / debug_wb_rf_wdata) and checks each register write against a golden trace.
- Golden entries arrive over a valid/ready stream from the testbench or trace loader and are buffered in an internal FIFO.
- Reports the first mismatch with captured context, or pass when the end PC retires.
- Sits beside the core in the SoC verification top; it never back-pressures the core.

Parameters:
- DEPTH, 16, golden-trace FIFO entries; power of 2, >= 2.
- END_PC, 32'hbfc0_0100, PC whose retirement signals test completion.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- start  in  1  pulse; arms checking (IDLE->RUN)
- debug_wb_pc  in  32  retiring PC from core
- debug_wb_rf_wen  in  4  byte write enables from core
- debug_wb_rf_wnum  in  5  destination register
- debug_wb_rf_wdata  in  32  write data
- trace_valid  in  1  golden entry valid
- trace_ready  out  1  FIFO can accept (= !full)
- trace_pc  in  32  golden PC
- trace_wnum  in  5  golden register number
- trace_wdata  in  32  golden data
- running  out  1  state == RUN
- pass  out  1  sticky; END_PC retired with no error
- error  out  1  sticky; first mismatch detected
- err_cause  out  3  0 none, 1 UNDERFLOW, 2 PC, 3 WNUM, 4 WDATA
- err_pc  out  32  core PC at the failing commit
- err_exp_data  out  32  golden wdata at failure (0 on UNDERFLOW)
- err_got_data  out  32  core wdata at failure
- commit_cnt  out  32  checked commits, saturating at 32'hffff_ffff

Behaviour:
- Reset (sync, rst=1 at a clk edge):
  - state=IDLE; FIFO empty; pass/error/running=0; err_cause/err_pc/err_exp_data/err_got_data/commit_cnt=0.
  - trace_ready=1 from the first cycle after reset.
  - Reset mid-run discards all buffered entries.
- FIFO:
  - Push when trace_valid && trace_ready, in any state.
  - Push and pop in the same cycle are allowed.
  - No bypass: an entry pushed in cycle N is poppable from cycle N+1.
  - Pointers wrap modulo DEPTH; full/empty are derived from an extra pointer bit.
- Commit event: state==RUN && |debug_wb_rf_wen && debug_wb_rf_wnum!=0. Commits in IDLE, DONE or ERROR are ignored.
- Check on a commit event (combinational against the FIFO head, results registered, so 1-cycle latency to outputs). Cause priority:
  - FIFO empty -> UNDERFLOW.
  - debug_wb_pc != head.pc -> PC.
  - debug_wb_rf_wnum != head.wnum -> WNUM.
  - For any byte i with debug_wb_rf_wen[i]=1, wdata byte i != head.wdata byte i -> WDATA. Masked bytes are ignored.
  - Pop the head whenever the FIFO is non-empty, whether or not the check passes.
  - commit_cnt increments on every commit event, including the failing one.
- State machine (IDLE, RUN, DONE, ERROR):
  - IDLE -> RUN on start.
  - RUN -> ERROR on any check failure: capture err_* and set error=1.
  - RUN -> DONE when debug_wb_pc==END_PC in RUN. The PC is compared every cycle, not only on commit events. Sets pass=1.
  - Same cycle END_PC retirement and check failure: ERROR wins, pass stays 0.
  - DONE and ERROR are terminal until rst; start is ignored outside IDLE.
  - running=1 only in RUN.
- err_* fields hold their values once error is set.
- Entries still left in the FIFO at DONE do not affect pass.

Decomposition:
- Package wb_trace_pkg: state enum (IDLE, RUN, DONE, ERROR); err_cause localparams; trace entry struct {pc[31:0], wnum[4:0], wdata[31:0]}, 69 bits.
- Sub-module trace_fifo: synchronous FIFO parameterised by DEPTH and width, with push/pop/full/empty/head ports.
- Checker FSM, comparator and counters live in wb_trace_checker.

Test Plan:
- Happy path: after reset, push 3 entries {bfc00000,r8,0x1}, {bfc00004,r9,0x2}, {bfc00008,r10,0x3}; pulse start; drive the matching commits, then retire PC bfc00100 -> pass=1, error=0, commit_cnt=3, state DONE.
- Data mismatch: golden {bfc00000,r8,0x12345678}; core commits wen=4'hf, r8, 0x12345679 -> next cycle error=1, err_cause=4, err_pc=bfc00000, err_exp_data=0x12345678, err_got_data=0x12345679; a later END_PC leaves pass=0.
- Byte mask: golden wdata 0xAABBCCDD; core wen=4'b0001, wdata 0x000000DD -> no error, commit_cnt=1.
- Underflow: start with an empty FIFO; core commits r3 at bfc00010 while trace_valid rises the same cycle -> err_cause=1, err_exp_data=0.
- Filtering and full/wrap:
  - Commits with wnum=0 or wen=0 are not checked and not counted.
  - Push 16 entries with DEPTH=16 -> trace_ready=0.
  - Push+pop in the same cycle holds occupancy; stream 40 entries through to confirm wrap-around.
- Reset mid-run: rst after 5 of 10 commits -> FIFO empty, commit_cnt=0, state IDLE, trace_ready=1.

Source files
------------

// File: rtl/wb_trace_pkg.sv
// Shared types for the writeback trace checker: checker states, error
// cause codes and the golden trace entry layout.
package wb_trace_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DONE  = 2'd2,
      ST_ERROR = 2'd3
   } state_e;

   localparam logic [2:0] CAUSE_NONE      = 3'd0;
   localparam logic [2:0] CAUSE_UNDERFLOW = 3'd1;
   localparam logic [2:0] CAUSE_PC        = 3'd2;
   localparam logic [2:0] CAUSE_WNUM      = 3'd3;
   localparam logic [2:0] CAUSE_WDATA     = 3'd4;

   typedef struct packed {
      logic [31:0] pc;
      logic [4:0]  wnum;
      logic [31:0] wdata;
   } trace_entry_t;

   localparam int TRACE_W = $bits(trace_entry_t);

   // Expands the per-byte write enables into a 32-bit compare mask.
   function automatic logic [31:0] byte_mask(input logic [3:0] wen);
      return {{8{wen[3]}}, {8{wen[2]}}, {8{wen[1]}}, {8{wen[0]}}};
   endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO buffering golden trace entries; head is the oldest
// entry, with no write-to-read bypass.
module trace_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 69
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic             do_push, do_pop;

   // The extra pointer bit separates the full case from the empty case.
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign head  = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      do_push  = push && !full;
      do_pop   = pop && !empty;
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= din;
      end
   end

endmodule

// File: rtl/wb_trace_checker.sv
// Compares every register writeback of the core against a buffered golden
// trace, latching the first mismatch or flagging pass at END_PC.
module wb_trace_checker
   import wb_trace_pkg::*;
#(
   parameter int          DEPTH  = 16,
   parameter logic [31:0] END_PC = 32'hbfc0_0100
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] debug_wb_pc,
   input  logic [3:0]  debug_wb_rf_wen,
   input  logic [4:0]  debug_wb_rf_wnum,
   input  logic [31:0] debug_wb_rf_wdata,
   input  logic        trace_valid,
   output logic        trace_ready,
   input  logic [31:0] trace_pc,
   input  logic [4:0]  trace_wnum,
   input  logic [31:0] trace_wdata,
   output logic        running,
   output logic        pass,
   output logic        error,
   output logic [2:0]  err_cause,
   output logic [31:0] err_pc,
   output logic [31:0] err_exp_data,
   output logic [31:0] err_got_data,
   output logic [31:0] commit_cnt
);

   state_e       state_q, state_d;
   logic         pass_q, pass_d;
   logic         error_q, error_d;
   logic [2:0]   err_cause_q, err_cause_d;
   logic [31:0]  err_pc_q, err_pc_d;
   logic [31:0]  err_exp_data_q, err_exp_data_d;
   logic [31:0]  err_got_data_q, err_got_data_d;
   logic [31:0]  commit_cnt_q, commit_cnt_d;

   logic         fifo_full, fifo_empty, fifo_pop;
   logic [TRACE_W-1:0] fifo_head_raw;
   trace_entry_t fifo_head, fifo_din;
   logic         commit;
   logic [2:0]   cause;

   assign fifo_din  = '{pc: trace_pc, wnum: trace_wnum, wdata: trace_wdata};
   assign fifo_head = trace_entry_t'(fifo_head_raw);

   trace_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (TRACE_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (trace_valid),
      .pop   (fifo_pop),
      .din   (fifo_din),
      .full  (fifo_full),
      .empty (fifo_empty),
      .head  (fifo_head_raw)
   );

   // The head is consumed on every commit, so one bad entry cannot shift
   // the alignment of the following checks.
   always_comb begin
      commit   = (state_q == ST_RUN) && (|debug_wb_rf_wen) &&
                 (debug_wb_rf_wnum != 5'd0);
      fifo_pop = commit;
      cause    = CAUSE_NONE;
      if (commit) begin
         if (fifo_empty) begin
            cause = CAUSE_UNDERFLOW;
         end else if (debug_wb_pc != fifo_head.pc) begin
            cause = CAUSE_PC;
         end else if (debug_wb_rf_wnum != fifo_head.wnum) begin
            cause = CAUSE_WNUM;
         end else if (((debug_wb_rf_wdata ^ fifo_head.wdata) &
                       byte_mask(debug_wb_rf_wen)) != 32'd0) begin
            cause = CAUSE_WDATA;
         end
      end
   end

   always_comb begin
      state_d        = state_q;
      pass_d         = pass_q;
      error_d        = error_q;
      err_cause_d    = err_cause_q;
      err_pc_d       = err_pc_q;
      err_exp_data_d = err_exp_data_q;
      err_got_data_d = err_got_data_q;
      commit_cnt_d   = commit_cnt_q;

      if (commit && (commit_cnt_q != 32'hffff_ffff)) begin
         commit_cnt_d = commit_cnt_q + 32'd1;
      end

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            // A failing check outranks END_PC retiring in the same cycle.
            if (cause != CAUSE_NONE) begin
               state_d        = ST_ERROR;
               error_d        = 1'b1;
               err_cause_d    = cause;
               err_pc_d       = debug_wb_pc;
               err_exp_data_d = fifo_empty ? 32'd0 : fifo_head.wdata;
               err_got_data_d = debug_wb_rf_wdata;
            end else if (debug_wb_pc == END_PC) begin
               state_d = ST_DONE;
               pass_d  = 1'b1;
            end
         end
         default: begin
            state_d = state_q;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         pass_q         <= 1'b0;
         error_q        <= 1'b0;
         err_cause_q    <= CAUSE_NONE;
         err_pc_q       <= '0;
         err_exp_data_q <= '0;
         err_got_data_q <= '0;
         commit_cnt_q   <= '0;
      end else begin
         state_q        <= state_d;
         pass_q         <= pass_d;
         error_q        <= error_d;
         err_cause_q    <= err_cause_d;
         err_pc_q       <= err_pc_d;
         err_exp_data_q <= err_exp_data_d;
         err_got_data_q <= err_got_data_d;
         commit_cnt_q   <= commit_cnt_d;
      end
   end

   assign trace_ready  = !fifo_full;
   assign running      = (state_q == ST_RUN);
   assign pass         = pass_q;
   assign error        = error_q;
   assign err_cause    = err_cause_q;
   assign err_pc       = err_pc_q;
   assign err_exp_data = err_exp_data_q;
   assign err_got_data = err_got_data_q;
   assign commit_cnt   = commit_cnt_q;

endmodule

// File: tb/tb_wb_trace_checker.sv
// Self-checking bench for wb_trace_checker: directed scenarios plus random
// traffic, all compared against a queue-based reference model.
module tb_wb_trace_checker;

   localparam int          DEPTH  = 16;
   localparam logic [31:0] END_PC = 32'hbfc0_0100;
   localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2, M_ERROR = 3;

   typedef struct {
      logic [31:0] pc;
      logic [4:0]  wnum;
      logic [31:0] wdata;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst, start;
   logic [31:0] debug_wb_pc;
   logic [3:0]  debug_wb_rf_wen;
   logic [4:0]  debug_wb_rf_wnum;
   logic [31:0] debug_wb_rf_wdata;
   logic        trace_valid, trace_ready;
   logic [31:0] trace_pc;
   logic [4:0]  trace_wnum;
   logic [31:0] trace_wdata;
   logic        running, pass, error;
   logic [2:0]  err_cause;
   logic [31:0] err_pc, err_exp_data, err_got_data, commit_cnt;

   int n_checks = 0;
   int n_fails  = 0;

   // Reference model state
   ent_t        m_q[$];
   int          m_state;
   logic        m_pass, m_err;
   logic [2:0]  m_cause;
   logic [31:0] m_pc, m_exp, m_got, m_cnt;

   always #5 clk = ~clk;

   wb_trace_checker #(.DEPTH(DEPTH), .END_PC(END_PC)) dut (
      .clk               (clk),
      .rst               (rst),
      .start             (start),
      .debug_wb_pc       (debug_wb_pc),
      .debug_wb_rf_wen   (debug_wb_rf_wen),
      .debug_wb_rf_wnum  (debug_wb_rf_wnum),
      .debug_wb_rf_wdata (debug_wb_rf_wdata),
      .trace_valid       (trace_valid),
      .trace_ready       (trace_ready),
      .trace_pc          (trace_pc),
      .trace_wnum        (trace_wnum),
      .trace_wdata       (trace_wdata),
      .running           (running),
      .pass              (pass),
      .error             (error),
      .err_cause         (err_cause),
      .err_pc            (err_pc),
      .err_exp_data      (err_exp_data),
      .err_got_data      (err_got_data),
      .commit_cnt        (commit_cnt)
   );

   task automatic checkOutput(input string tag, input logic [31:0] got,
                              input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t",
                  tag, got, exp, $time);
      end
   endtask

   // One clock of the model: the golden queue is popped on a commit and
   // appended on an accepted push, both judged from pre-edge occupancy.
   task automatic modelStep(input logic i_rst, i_start, input logic [31:0] i_pc,
                            input logic [3:0] i_wen, input logic [4:0] i_wnum,
                            input logic [31:0] i_wdata, input logic i_tv,
                            input logic [31:0] i_tpc, input logic [4:0] i_twnum,
                            input logic [31:0] i_twdata);
      bit   room, commit, was_empty;
      int   cause;
      ent_t h;
      if (i_rst) begin
         m_q.delete();
         m_state = M_IDLE;
         m_pass = 0; m_err = 0; m_cause = 0;
         m_pc = 0; m_exp = 0; m_got = 0; m_cnt = 0;
         return;
      end
      room      = (m_q.size() < DEPTH);
      commit    = (m_state == M_RUN) && (i_wen != 0) && (i_wnum != 0);
      was_empty = (m_q.size() == 0);
      cause     = 0;
      if (commit) begin
         if (was_empty) begin
            cause = 1;
         end else begin
            h = m_q.pop_front();
            if (i_pc != h.pc) cause = 2;
            else if (i_wnum != h.wnum) cause = 3;
            else begin
               for (int b = 0; b < 4; b++)
                  if (i_wen[b] && (i_wdata[8*b +: 8] != h.wdata[8*b +: 8]))
                     cause = 4;
            end
         end
         if (m_cnt != 32'hffff_ffff) m_cnt = m_cnt + 1;
      end
      if (m_state == M_RUN) begin
         if (cause != 0) begin
            m_state = M_ERROR;
            m_err   = 1;
            m_cause = 3'(cause);
            m_pc    = i_pc;
            m_exp   = was_empty ? 32'd0 : h.wdata;
            m_got   = i_wdata;
         end else if (i_pc == END_PC) begin
            m_state = M_DONE;
            m_pass  = 1;
         end
      end else if (m_state == M_IDLE && i_start) begin
         m_state = M_RUN;
      end
      if (i_tv && room) m_q.push_back('{pc: i_tpc, wnum: i_twnum, wdata: i_twdata});
   endtask

   task automatic checkAll();
      checkOutput("trace_ready", {31'd0, trace_ready}, {31'd0, m_q.size() < DEPTH});
      checkOutput("running", {31'd0, running}, {31'd0, m_state == M_RUN});
      checkOutput("pass", {31'd0, pass}, {31'd0, m_pass});
      checkOutput("error", {31'd0, error}, {31'd0, m_err});
      checkOutput("err_cause", {29'd0, err_cause}, {29'd0, m_cause});
      checkOutput("err_pc", err_pc, m_pc);
      checkOutput("err_exp_data", err_exp_data, m_exp);
      checkOutput("err_got_data", err_got_data, m_got);
      checkOutput("commit_cnt", commit_cnt, m_cnt);
   endtask

   task automatic applyStimulus(input logic i_rst, i_start, input logic [31:0] i_pc,
                                input logic [3:0] i_wen, input logic [4:0] i_wnum,
                                input logic [31:0] i_wdata, input logic i_tv,
                                input logic [31:0] i_tpc, input logic [4:0] i_twnum,
                                input logic [31:0] i_twdata);
      rst = i_rst; start = i_start;
      debug_wb_pc = i_pc; debug_wb_rf_wen = i_wen;
      debug_wb_rf_wnum = i_wnum; debug_wb_rf_wdata = i_wdata;
      trace_valid = i_tv; trace_pc = i_tpc;
      trace_wnum = i_twnum; trace_wdata = i_twdata;
      @(posedge clk);
      modelStep(i_rst, i_start, i_pc, i_wen, i_wnum, i_wdata,
                i_tv, i_tpc, i_twnum, i_twdata);
      #1;
      checkAll();
   endtask

   task automatic doReset();
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask
   task automatic idleCycle();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask
   task automatic startCycle();
      applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask
   task automatic pushEntry(input logic [31:0] p, input logic [4:0] n,
                            input logic [31:0] d);
      applyStimulus(0, 0, 0, 0, 0, 0, 1, p, n, d);
   endtask
   task automatic commitCycle(input logic [31:0] p, input logic [3:0] w,
                              input logic [4:0] n, input logic [31:0] d);
      applyStimulus(0, 0, p, w, n, d, 0, 0, 0, 0);
   endtask
   task automatic commitHead();
      commitCycle(m_q[0].pc, 4'hf, m_q[0].wnum, m_q[0].wdata);
   endtask

   initial begin
      ent_t        h;
      logic [31:0] mask, p, d, cd;
      logic [3:0]  w;
      logic [4:0]  n;
      logic        tv, st;

      doReset();
      doReset();
      checkOutput("reset_ready", {31'd0, trace_ready}, 32'd1);
      checkOutput("reset_cnt", commit_cnt, 32'd0);

      $display("[TB] happy path");
      pushEntry(32'hbfc0_0000, 5'd8, 32'h1);
      pushEntry(32'hbfc0_0004, 5'd9, 32'h2);
      pushEntry(32'hbfc0_0008, 5'd10, 32'h3);
      startCycle();
      commitCycle(32'hbfc0_0000, 4'hf, 5'd8, 32'h1);
      commitCycle(32'hbfc0_0004, 4'hf, 5'd9, 32'h2);
      commitCycle(32'hbfc0_0008, 4'hf, 5'd10, 32'h3);
      commitCycle(END_PC, 4'h0, 5'd0, 32'h0);
      checkOutput("happy_pass", {31'd0, pass}, 32'd1);
      checkOutput("happy_error", {31'd0, error}, 32'd0);
      checkOutput("happy_cnt", commit_cnt, 32'd3);
      checkOutput("happy_running", {31'd0, running}, 32'd0);

      $display("[TB] data mismatch");
      doReset();
      pushEntry(32'hbfc0_0000, 5'd8, 32'h1234_5678);
      startCycle();
      commitCycle(32'hbfc0_0000, 4'hf, 5'd8, 32'h1234_5679);
      checkOutput("wdata_error", {31'd0, error}, 32'd1);
      checkOutput("wdata_cause", {29'd0, err_cause}, 32'd4);
      checkOutput("wdata_pc", err_pc, 32'hbfc0_0000);
      checkOutput("wdata_exp", err_exp_data, 32'h1234_5678);
      checkOutput("wdata_got", err_got_data, 32'h1234_5679);
      commitCycle(END_PC, 4'h0, 5'd0, 32'h0);
      checkOutput("wdata_no_pass", {31'd0, pass}, 32'd0);

      $display("[TB] byte mask");
      doReset();
      pushEntry(32'hbfc0_0000, 5'd8, 32'hAABB_CCDD);
      startCycle();
      commitCycle(32'hbfc0_0000, 4'b0001, 5'd8, 32'h0000_00DD);
      checkOutput("mask_error", {31'd0, error}, 32'd0);
      checkOutput("mask_cnt", commit_cnt, 32'd1);

      $display("[TB] underflow");
      doReset();
      startCycle();
      applyStimulus(0, 0, 32'hbfc0_0010, 4'hf, 5'd3, 32'h55, 1, 32'hbfc0_0010, 5'd3, 32'h55);
      checkOutput("uflow_cause", {29'd0, err_cause}, 32'd1);
      checkOutput("uflow_exp", err_exp_data, 32'd0);
      checkOutput("uflow_pc", err_pc, 32'hbfc0_0010);

      $display("[TB] filtering");
      doReset();
      pushEntry(32'hbfc0_0020, 5'd4, 32'h44);
      startCycle();
      commitCycle(32'hbfc0_0020, 4'hf, 5'd0, 32'h99);
      commitCycle(32'hbfc0_0020, 4'h0, 5'd4, 32'h99);
      checkOutput("filter_cnt", commit_cnt, 32'd0);
      checkOutput("filter_error", {31'd0, error}, 32'd0);
      commitHead();
      checkOutput("filter_cnt_after", commit_cnt, 32'd1);

      $display("[TB] full and wrap");
      doReset();
      for (int k = 0; k < DEPTH; k++) pushEntry(32'hbfc0_0000 + 32'(4*k), 5'(k % 31 + 1), 32'(k * 32'h0101_0101));
      checkOutput("full_ready", {31'd0, trace_ready}, 32'd0);
      pushEntry(32'hdead_beef, 5'd1, 32'hdead_beef);
      startCycle();
      commitHead();
      for (int k = 0; k < 40; k++) begin
         h = m_q[0];
         applyStimulus(0, 0, h.pc, 4'hf, h.wnum, h.wdata, 1,
                       32'hbfc0_0040 + 32'(4*k), 5'(k % 31 + 1), $urandom);
      end
      checkOutput("wrap_cnt", commit_cnt, 32'd41);
      checkOutput("wrap_error", {31'd0, error}, 32'd0);
      checkOutput("wrap_ready", {31'd0, trace_ready}, 32'd1);

      $display("[TB] reset mid-run");
      doReset();
      for (int k = 0; k < 10; k++) pushEntry(32'hbfc0_0000 + 32'(4*k), 5'd7, 32'(k));
      startCycle();
      for (int k = 0; k < 5; k++) commitHead();
      doReset();
      checkOutput("midrst_cnt", commit_cnt, 32'd0);
      checkOutput("midrst_ready", {31'd0, trace_ready}, 32'd1);
      checkOutput("midrst_running", {31'd0, running}, 32'd0);
      startCycle();
      commitCycle(32'hbfc0_0000, 4'hf, 5'd7, 32'd0);
      checkOutput("midrst_uflow", {29'd0, err_cause}, 32'd1);

      $display("[TB] random traffic");
      for (int r = 0; r < 40; r++) begin
         doReset();
         for (int c = 0; c < 60; c++) begin
            st = ($urandom % 6 == 0);
            tv = ($urandom % 2 == 0);
            p = 32'hbfc0_0000 + 32'(4 * ($urandom % 32));
            if ($urandom % 40 == 0) p = END_PC;
            w = 4'($urandom);
            n = 5'($urandom);
            d = $urandom;
            if (m_q.size() != 0 && $urandom % 10 != 0) begin
               h = m_q[0];
               mask = 32'd0;
               for (int b = 0; b < 4; b++) if (w[b]) mask[8*b +: 8] = 8'hff;
               if ($urandom % 12 != 0) p = h.pc;
               if ($urandom % 12 != 0) n = h.wnum;
               cd = h.wdata ^ ($urandom & ~mask);
               if ($urandom % 12 == 0) cd = cd ^ 32'h0000_0100;
               d = cd;
            end
            applyStimulus(0, st, p, w, n, d, tv,
                          32'hbfc0_0000 + 32'(4 * ($urandom % 32)),
                          5'($urandom), $urandom);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
